// File: rtl/oh_to_idx_serializer_pkg.sv
// Shared constants and helpers for the one-hot-to-index serializer slice.
package oh_to_idx_serializer_pkg;

  localparam DIR_LSB0 = "LSB0";

  // Mask bit position to emitted index: identity for LSB0, mirrored otherwise.
  function automatic int unsigned map_index(input int unsigned pos, input int unsigned n,
                                            input bit lsb0);
    return lsb0 ? pos : n - 1 - pos;
  endfunction

endpackage

// File: rtl/oh_to_idx.sv
// Combinational one-hot to index encoder; DIRECTION mirrors the index-to-one-hot decoder.
module oh_to_idx
  import oh_to_idx_serializer_pkg::*;
#(
  parameter int NUM_SIGNALS = 4,
  parameter     DIRECTION   = "LSB0",
  parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
  input  logic [NUM_SIGNALS-1:0] one_hot,
  output logic [INDEX_WIDTH-1:0] index
);

  localparam bit LSB0 = (DIRECTION == DIR_LSB0);

  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot[i]) index = index | INDEX_WIDTH'(map_index(i, NUM_SIGNALS, LSB0));
    end
  end

endmodule

// File: rtl/oh_to_idx_serializer.sv
// Accepts a multi-hot mask and emits one index/one-hot beat per set bit,
// in ascending mapped-index order, with back-to-back mask acceptance on the last beat.
module oh_to_idx_serializer
  import oh_to_idx_serializer_pkg::*;
#(
  parameter int NUM_SIGNALS = 4,
  parameter     DIRECTION   = "LSB0",
  parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mask_valid,
  output logic                   mask_ready,
  input  logic [NUM_SIGNALS-1:0] mask,
  output logic                   idx_valid,
  input  logic                   idx_ready,
  output logic [INDEX_WIDTH-1:0] index,
  output logic [NUM_SIGNALS-1:0] one_hot,
  output logic                   idx_last
);

  localparam bit LSB0 = (DIRECTION == DIR_LSB0);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_SIGNALS-1:0] pending, pending_nxt;
  logic [NUM_SIGNALS-1:0] scan, scan_sel, sel;
  logic                   single;

  // Non-LSB0 selection isolates the lowest bit of the bit-reversed vector, then reverses back.
  always_comb begin
    scan = '0;
    sel  = '0;
    for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
      scan[i] = LSB0 ? pending[i] : pending[NUM_SIGNALS-1-i];
    end
    scan_sel = scan & (~scan + NUM_SIGNALS'(1));
    for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
      sel[i] = LSB0 ? scan_sel[i] : scan_sel[NUM_SIGNALS-1-i];
    end
  end

  assign single = ((pending & (pending - NUM_SIGNALS'(1))) == '0);

  oh_to_idx #(
    .NUM_SIGNALS (NUM_SIGNALS),
    .DIRECTION   (DIRECTION),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_oh_to_idx (
    .one_hot (sel),
    .index   (index)
  );

  // pending is all-zero in IDLE, so sel and index fall to zero there.
  assign idx_valid  = (state == EMIT);
  assign one_hot    = sel;
  assign idx_last   = (state == EMIT) && single;
  assign mask_ready = (state == IDLE) || ((state == EMIT) && single && idx_ready);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (mask_valid && (mask != '0)) begin
          pending_nxt = mask;
          state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (idx_ready) begin
          if (single) begin
            pending_nxt = '0;
            state_nxt   = IDLE;
            if (mask_valid && (mask != '0)) begin
              pending_nxt = mask;
              state_nxt   = EMIT;
            end
          end else begin
            pending_nxt = pending & ~sel;
          end
        end
      end
      default: begin
        pending_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_oh_to_idx_serializer.sv
// Self-checking bench: LSB0 and MSB0 instances driven in lockstep against a queue-based model.
module tb_oh_to_idx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mask_valid;
  logic [7:0] mask;
  logic       idx_ready;

  logic       mr_l, iv_l, last_l;
  logic [2:0] idx_l;
  logic [7:0] oh_l;
  logic       mr_m, iv_m, last_m;
  logic [2:0] idx_m;
  logic [7:0] oh_m;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Remaining expected indices for each direction, in emission order.
  int ql[$];
  int qm[$];

  always #5 clk = ~clk;

  oh_to_idx_serializer #(
    .NUM_SIGNALS (8),
    .DIRECTION   ("LSB0")
  ) dut_l (
    .clk        (clk),
    .reset      (reset),
    .mask_valid (mask_valid),
    .mask_ready (mr_l),
    .mask       (mask),
    .idx_valid  (iv_l),
    .idx_ready  (idx_ready),
    .index      (idx_l),
    .one_hot    (oh_l),
    .idx_last   (last_l)
  );

  oh_to_idx_serializer #(
    .NUM_SIGNALS (8),
    .DIRECTION   ("MSB0")
  ) dut_m (
    .clk        (clk),
    .reset      (reset),
    .mask_valid (mask_valid),
    .mask_ready (mr_m),
    .mask       (mask),
    .idx_valid  (iv_m),
    .idx_ready  (idx_ready),
    .index      (idx_m),
    .one_hot    (oh_m),
    .idx_last   (last_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void load(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) ql.push_back(i);
    for (int j = 0; j < 8; j++) if (m[7-j]) qm.push_back(j);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".L.valid"}, 32'(iv_l), 32'd0);
    check({tag, ".L.index"}, 32'(idx_l), 32'd0);
    check({tag, ".L.onehot"}, 32'(oh_l), 32'd0);
    check({tag, ".L.last"}, 32'(last_l), 32'd0);
    check({tag, ".L.ready"}, 32'(mr_l), 32'd1);
    check({tag, ".M.valid"}, 32'(iv_m), 32'd0);
    check({tag, ".M.index"}, 32'(idx_m), 32'd0);
    check({tag, ".M.onehot"}, 32'(oh_m), 32'd0);
    check({tag, ".M.last"}, 32'(last_m), 32'd0);
    check({tag, ".M.ready"}, 32'(mr_m), 32'd1);
  endtask

  // Called at posedge+1; drives inputs, checks all outputs, advances one clock.
  task automatic cycle(input logic mv, input logic [7:0] m, input logic ir);
    bit          ne, one;
    bit          exp_mr;
    logic [7:0]  eoh_l, eoh_m;
    int          eil, eim;
    mask_valid = mv;
    mask       = m;
    idx_ready  = ir;
    #1;
    ne     = (ql.size() != 0);
    one    = (ql.size() == 1);
    eil    = ne ? ql[0] : 0;
    eim    = ne ? qm[0] : 0;
    eoh_l  = ne ? (8'h01 << eil) : 8'h00;
    eoh_m  = ne ? (8'h01 << (7 - eim)) : 8'h00;
    exp_mr = !ne || (one && ir);
    check("L.valid", 32'(iv_l), 32'(ne));
    check("L.index", 32'(idx_l), 32'(eil));
    check("L.onehot", 32'(oh_l), 32'(eoh_l));
    check("L.last", 32'(last_l), 32'(one));
    check("L.ready", 32'(mr_l), 32'(exp_mr));
    check("M.valid", 32'(iv_m), 32'(ne));
    check("M.index", 32'(idx_m), 32'(eim));
    check("M.onehot", 32'(oh_m), 32'(eoh_m));
    check("M.last", 32'(last_m), 32'(one));
    check("M.ready", 32'(mr_m), 32'(exp_mr));
    @(posedge clk);
    if (ne && ir) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
    if (mv && exp_mr) load(m);
    #1;
  endtask

  initial begin
    logic [7:0] rm;
    reset      = 1'b0;
    mask_valid = 1'b0;
    mask       = '0;
    idx_ready  = 1'b0;
    #2;
    check_idle_outputs("reset");
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic emission, both directions, mask 0101_0010.
    cycle(1'b1, 8'h52, 1'b1);
    check("basic.L.idx0", 32'(idx_l), 32'd1);
    check("basic.M.idx0", 32'(idx_m), 32'd1);
    check("basic.M.oh0", 32'(oh_m), 32'h40);
    cycle(1'b0, 8'h00, 1'b1);
    check("basic.L.idx1", 32'(idx_l), 32'd4);
    check("basic.M.idx1", 32'(idx_m), 32'd3);
    cycle(1'b0, 8'h00, 1'b1);
    check("basic.L.idx2", 32'(idx_l), 32'd6);
    check("basic.L.oh2", 32'(oh_l), 32'h40);
    check("basic.M.idx2", 32'(idx_m), 32'd6);
    check("basic.M.oh2", 32'(oh_m), 32'h02);
    check("basic.L.last2", 32'(last_l), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: first beat of 0x0C held for four cycles.
    cycle(1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      check("bp.L.hold_idx", 32'(idx_l), 32'd2);
      check("bp.L.hold_oh", 32'(oh_l), 32'h04);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("bp.L.second", 32'(idx_l), 32'd3);
    cycle(1'b0, 8'h00, 1'b1);
    check("bp.L.done", 32'(iv_l), 32'd0);

    // Back-to-back: 0x81 then 0x80 offered during the final beat.
    cycle(1'b1, 8'h81, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("b2b.L.final_idx", 32'(idx_l), 32'd7);
    cycle(1'b1, 8'h80, 1'b1);
    check("b2b.L.no_bubble", 32'(iv_l), 32'd1);
    check("b2b.L.reemit", 32'(idx_l), 32'd7);
    check("b2b.L.last", 32'(last_l), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Edge-case masks: zero mask dropped, single-bit mask.
    cycle(1'b1, 8'h00, 1'b1);
    check("zero.L.no_valid", 32'(iv_l), 32'd0);
    cycle(1'b1, 8'h01, 1'b1);
    check("one.L.idx", 32'(idx_l), 32'd0);
    check("one.L.last", 32'(last_l), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-emission of 0xF0.
    cycle(1'b1, 8'hF0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    ql.delete();
    qm.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h02, 1'b1);
    check("postreset.L.idx", 32'(idx_l), 32'd1);
    check("postreset.L.last", 32'(last_l), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic with random backpressure and occasional zero/sparse masks.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       rm = 8'h00;
        1:       rm = 8'h01 << $urandom_range(0, 7);
        default: rm = 8'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), rm, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
